// File: rtl/exe_arbiter.sv
// Two-requester arbiter in front of a shared combinational exe_unit: captures the
// winner's operands, latches the result after one EXEC cycle, and holds it until ready or timeout.
module exe_arbiter #(
  parameter int BITS    = 8,
  parameter int OPER    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            i_clk_p,
  input  logic            i_rst_n,
  input  logic [1:0]      i_req,
  input  logic [BITS-1:0] i_argA0,
  input  logic [BITS-1:0] i_argB0,
  input  logic [OPER-1:0] i_oper0,
  input  logic [BITS-1:0] i_argA1,
  input  logic [BITS-1:0] i_argB1,
  input  logic [OPER-1:0] i_oper1,
  output logic [1:0]      o_ack,
  output logic [BITS-1:0] o_alu_argA,
  output logic [BITS-1:0] o_alu_argB,
  output logic [OPER-1:0] o_alu_oper,
  input  logic [BITS-1:0] i_alu_result,
  input  logic [3:0]      i_alu_flags,
  output logic [1:0]      o_valid,
  input  logic [1:0]      i_ready,
  output logic [BITS-1:0] o_result,
  output logic [3:0]      o_flags,
  output logic            o_timeout,
  output logic            o_timeout_id,
  output logic            o_busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [7:0] TO_LOAD = 8'(TIMEOUT);

  state_t          state, state_nxt;
  logic            owner;
  logic            prio;
  logic            contended;
  logic            gap;
  logic [7:0]      cnt;
  logic [BITS-1:0] arg_a, arg_b;
  logic [OPER-1:0] oper;
  logic            ready_own;
  logic            start;

  function automatic logic pick_winner(input logic [1:0] req, input logic ptr);
    return (req == 2'b11) ? ptr : req[1];
  endfunction

  // gap forces one IDLE cycle after every completion before requests are sampled again
  assign ready_own = i_ready[owner];
  assign start     = (state == IDLE) && (|i_req) && !gap;

  always_ff @(posedge i_clk_p) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? EXEC : IDLE;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = (ready_own || cnt == 8'd1) ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ack   = 2'b00;
    o_valid = 2'b00;
    o_busy  = (state != IDLE);
    if (state == EXEC) o_ack[owner]   = 1'b1;
    if (state == RESP) o_valid[owner] = 1'b1;
  end

  always_ff @(posedge i_clk_p) begin
    if (!i_rst_n) begin
      owner        <= 1'b0;
      prio         <= 1'b0;
      contended    <= 1'b0;
      gap          <= 1'b0;
      cnt          <= 8'd0;
      arg_a        <= '0;
      arg_b        <= '0;
      oper         <= '0;
      o_result     <= '0;
      o_flags      <= 4'd0;
      o_timeout    <= 1'b0;
      o_timeout_id <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      gap       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            owner     <= pick_winner(i_req, prio);
            contended <= (i_req == 2'b11);
            arg_a     <= pick_winner(i_req, prio) ? i_argA1 : i_argA0;
            arg_b     <= pick_winner(i_req, prio) ? i_argB1 : i_argB0;
            oper      <= pick_winner(i_req, prio) ? i_oper1 : i_oper0;
          end
        end
        EXEC: begin
          o_result <= i_alu_result;
          o_flags  <= i_alu_flags;
          cnt      <= TO_LOAD;
        end
        RESP: begin
          if (ready_own || cnt == 8'd1) begin
            gap <= 1'b1;
            if (contended) prio <= ~owner;
            if (!ready_own) begin
              o_timeout    <= 1'b1;
              o_timeout_id <= owner;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_alu_argA = arg_a;
  assign o_alu_argB = arg_b;
  assign o_alu_oper = oper;

endmodule
